hawk_decmpresn_mngr: RTL and testbench

Decompression manager for the HACD/Hawk memory-compaction engine: the inverse of compression. On a trigger it reads one compressed chunk (64 B or 128 B) out of a ZsPage and streams it into the decompressor. It waits for decompression to finish, then drains the 4 KB result from the decompressor output FIFO as AXI4 write bursts into a free uncompressed frame. Finally it posts a TOL update so the page walker can retarget the translation.

---
 rtl/hawk_decmpresn_mngr.sv | 228 ++++++++++++++++++++++
 tb/tb_hawk_decmpresn_mngr.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hawk_decmpresn_mngr.sv
// Hawk decompression manager: fetches one compressed chunk over AXI,
// feeds the decompressor, writes the 4 KB result back and posts a TOL update.
module hawk_decmpresn_mngr #(
    parameter int DATA_W = 512,
    parameter int ADDR_W = 48
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                dcmp_trigger,
    input  logic [ADDR_W-13:0]  zspg_way,
    input  logic [11:0]         zspg_off,
    input  logic [13:0]         cmp_size,
    input  logic [ADDR_W-13:0]  dst_way,
    output logic                arvalid,
    input  logic                arready,
    output logic [ADDR_W-1:0]   araddr,
    output logic [7:0]          arlen,
    input  logic                rvalid,
    output logic                rready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    output logic                awvalid,
    input  logic                awready,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [7:0]          awlen,
    output logic                wvalid,
    input  logic                wready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wlast,
    input  logic                bvalid,
    output logic                bready,
    input  logic [1:0]          bresp,
    output logic                dcmp_start,
    output logic                dcmp_in_vld,
    output logic [DATA_W-1:0]   dcmp_in_data,
    input  logic                dcmp_done,
    input  logic                ofifo_empty,
    input  logic [DATA_W-1:0]   ofifo_data,
    output logic                ofifo_rd_en,
    output logic                tol_upd_vld,
    output logic [ADDR_W-13:0]  tol_upd_way,
    output logic                dcmp_mngr_done,
    output logic                dcmp_err
);

    typedef enum logic [3:0] {
        S_IDLE, S_RD_REQ, S_RD_DATA, S_DCMP_WAIT,
        S_WR_AW, S_WR_DATA, S_WR_RESP, S_DONE, S_ERR
    } state_e;

    state_e              state_q, state_d;
    logic                arvalid_q, arvalid_d;
    logic [ADDR_W-1:0]   araddr_q, araddr_d;
    logic [7:0]          arlen_q, arlen_d;
    logic                awvalid_q, awvalid_d;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
    logic [7:0]          awlen_q, awlen_d;
    logic [1:0]          burst_q, burst_d;
    logic [3:0]          beat_q, beat_d;
    logic [ADDR_W-13:0]  dst_q, dst_d;
    logic                start_q, start_d;
    logic                done_q, done_d;
    logic                tol_vld_q, tol_vld_d;
    logic [ADDR_W-13:0]  tol_way_q, tol_way_d;
    logic                err_q, err_d;
    logic [1:0]          burst_nx;
    logic                w_hs;

    assign burst_nx = burst_q + 2'd1;

    assign rready       = (state_q == S_RD_DATA);
    assign dcmp_in_vld  = rready & rvalid;
    assign dcmp_in_data = rdata;
    assign wvalid       = (state_q == S_WR_DATA) & ~ofifo_empty;
    assign wdata        = ofifo_data;
    assign wstrb        = '1;
    assign wlast        = (state_q == S_WR_DATA) & (beat_q == 4'hF);
    assign w_hs         = wvalid & wready;
    assign ofifo_rd_en  = w_hs;
    assign bready       = (state_q == S_WR_RESP);

    assign arvalid        = arvalid_q;
    assign araddr         = araddr_q;
    assign arlen          = arlen_q;
    assign awvalid        = awvalid_q;
    assign awaddr         = awaddr_q;
    assign awlen          = awlen_q;
    assign dcmp_start     = start_q;
    assign tol_upd_vld    = tol_vld_q;
    assign tol_upd_way    = tol_way_q;
    assign dcmp_mngr_done = done_q;
    assign dcmp_err       = err_q;

    always_comb begin
        state_d   = state_q;
        arvalid_d = arvalid_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        awvalid_d = awvalid_q;
        awaddr_d  = awaddr_q;
        awlen_d   = awlen_q;
        burst_d   = burst_q;
        beat_d    = beat_q;
        dst_d     = dst_q;
        start_d   = 1'b0;
        done_d    = 1'b0;
        tol_vld_d = 1'b0;
        tol_way_d = tol_way_q;
        err_d     = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (dcmp_trigger) begin
                    dst_d = dst_way;
                    if (cmp_size == 14'd64 || cmp_size == 14'd128) begin
                        araddr_d  = {zspg_way, zspg_off};
                        arlen_d   = (cmp_size == 14'd128) ? 8'd1 : 8'd0;
                        arvalid_d = 1'b1;
                        state_d   = S_RD_REQ;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end
                end
            end
            S_RD_REQ: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    state_d   = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (rvalid) begin
                    if (rresp != 2'd0) begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end else if (rlast) begin
                        start_d = 1'b1;
                        state_d = S_DCMP_WAIT;
                    end
                end
            end
            S_DCMP_WAIT: begin
                // a done seen while start is still being issued is stale
                if (dcmp_done && !start_q) begin
                    burst_d   = 2'd0;
                    awaddr_d  = {dst_q, 12'h000};
                    awlen_d   = 8'd15;
                    awvalid_d = 1'b1;
                    state_d   = S_WR_AW;
                end
            end
            S_WR_AW: begin
                if (awready) begin
                    awvalid_d = 1'b0;
                    beat_d    = 4'd0;
                    state_d   = S_WR_DATA;
                end
            end
            S_WR_DATA: begin
                if (w_hs) begin
                    beat_d = beat_q + 4'd1;
                    if (beat_q == 4'hF) state_d = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (bvalid) begin
                    if (bresp != 2'd0) begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end else if (burst_q != 2'd3) begin
                        burst_d   = burst_nx;
                        awaddr_d  = {dst_q, 12'h000}
                                  + ADDR_W'({burst_nx, 10'h000});
                        awvalid_d = 1'b1;
                        state_d   = S_WR_AW;
                    end else begin
                        done_d    = 1'b1;
                        tol_vld_d = 1'b1;
                        tol_way_d = dst_q;
                        state_d   = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            awvalid_q <= 1'b0;
            awaddr_q  <= '0;
            awlen_q   <= '0;
            burst_q   <= '0;
            beat_q    <= '0;
            dst_q     <= '0;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
            tol_vld_q <= 1'b0;
            tol_way_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            arvalid_q <= arvalid_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            awvalid_q <= awvalid_d;
            awaddr_q  <= awaddr_d;
            awlen_q   <= awlen_d;
            burst_q   <= burst_d;
            beat_q    <= beat_d;
            dst_q     <= dst_d;
            start_q   <= start_d;
            done_q    <= done_d;
            tol_vld_q <= tol_vld_d;
            tol_way_q <= tol_way_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_hawk_decmpresn_mngr.sv
// Directed bench for hawk_decmpresn_mngr with cycle-level AXI,
// decompressor and output-FIFO models driven on the falling edge.
module tb_hawk_decmpresn_mngr;
    localparam int DW = 512;
    localparam int AW = 48;
    localparam int FW = AW - 12;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    logic          dcmp_trigger;
    logic [FW-1:0] zspg_way, dst_way, tol_upd_way;
    logic [11:0]   zspg_off;
    logic [13:0]   cmp_size;
    logic          arvalid, arready, rvalid, rready, rlast;
    logic [AW-1:0] araddr, awaddr;
    logic [7:0]    arlen, awlen;
    logic [DW-1:0] rdata, wdata, dcmp_in_data, ofifo_data;
    logic [1:0]    rresp, bresp;
    logic          awvalid, awready, wvalid, wready, wlast;
    logic [DW/8-1:0] wstrb;
    logic          bvalid, bready, dcmp_start, dcmp_in_vld, dcmp_done;
    logic          ofifo_empty, ofifo_rd_en, tol_upd_vld;
    logic          dcmp_mngr_done, dcmp_err;

    hawk_decmpresn_mngr #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .dcmp_trigger(dcmp_trigger),
        .zspg_way(zspg_way), .zspg_off(zspg_off), .cmp_size(cmp_size),
        .dst_way(dst_way), .arvalid(arvalid), .arready(arready),
        .araddr(araddr), .arlen(arlen), .rvalid(rvalid), .rready(rready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .awvalid(awvalid),
        .awready(awready), .awaddr(awaddr), .awlen(awlen), .wvalid(wvalid),
        .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .dcmp_start(dcmp_start), .dcmp_in_vld(dcmp_in_vld),
        .dcmp_in_data(dcmp_in_data), .dcmp_done(dcmp_done),
        .ofifo_empty(ofifo_empty), .ofifo_data(ofifo_data),
        .ofifo_rd_en(ofifo_rd_en), .tol_upd_vld(tol_upd_vld),
        .tol_upd_way(tol_upd_way), .dcmp_mngr_done(dcmp_mngr_done),
        .dcmp_err(dcmp_err)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rpat(input int i);
        return {16{32'hC0DE_0000 + 32'(i)}};
    endfunction

    function automatic logic [DW-1:0] wpat(input int i);
        return {16{32'hBEEF_0000 + 32'(i)}};
    endfunction

    bit stall, early, trig_next, trig2_fired;
    bit aw_open, b_pend, ar_hold, aw_hold, w_hold;
    int lat, rerr_beat, berr_burst, trig2_w;
    int r_left, r_idx, dl, fifo_cnt, fifo_next, w_cnt, b_idx;
    int ar_cnt, in_cnt, in_bad, start_cnt, start_cyc, rlast_cyc;
    int aw_cnt, awlen_bad, w_bad, wlast_bad, wstrb_bad, rd_bad, ovl_bad;
    int stab_bad, tol_cnt, done_cnt, done_cyc, err_vld_bad, cyc, trig_cyc;
    logic [AW-1:0] araddr_s, ar_prev, aw_prev;
    logic [AW-1:0] aw_addr [4];
    logic [7:0]    arlen_s;
    logic [FW-1:0] tol_way_s;
    logic [DW-1:0] w_prev;

    task automatic model_clear();
        stall = 0; early = 0; trig_next = 0; trig2_fired = 0;
        aw_open = 0; b_pend = 0; ar_hold = 0; aw_hold = 0; w_hold = 0;
        lat = 1; rerr_beat = -1; berr_burst = -1; trig2_w = -1;
        r_left = 0; r_idx = 0; dl = 0; fifo_cnt = 0; fifo_next = 0;
        w_cnt = 0; b_idx = 0; ar_cnt = 0; in_cnt = 0; in_bad = 0;
        start_cnt = 0; start_cyc = 0; rlast_cyc = 0; aw_cnt = 0;
        awlen_bad = 0; w_bad = 0; wlast_bad = 0; wstrb_bad = 0;
        rd_bad = 0; ovl_bad = 0; stab_bad = 0; tol_cnt = 0;
        done_cnt = 0; done_cyc = 0; err_vld_bad = 0; cyc = 0;
        trig_cyc = 0; araddr_s = '0; arlen_s = '0; tol_way_s = '0;
        for (int i = 0; i < 4; i++) aw_addr[i] = '0;
        dcmp_trigger = 0; zspg_way = '0; zspg_off = '0; cmp_size = '0;
        dst_way = '0; arready = 0; rvalid = 0; rdata = '0; rresp = 0;
        rlast = 0; awready = 0; wready = 0; bvalid = 0; bresp = 0;
        dcmp_done = 0; ofifo_empty = 1; ofifo_data = '0;
    endtask

    task automatic step();
        @(negedge clk_i);
        dcmp_trigger = trig_next;
        trig_next = 0;
        arready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        rvalid = (r_left > 0) &&
                 (!stall || rvalid || $urandom_range(0, 2) != 0);
        rdata = rvalid ? rpat(r_idx) : '0;
        rlast = rvalid && (r_left == 1);
        rresp = (rvalid && r_idx == rerr_beat) ? 2'd2 : 2'd0;
        dcmp_done = early && rvalid;
        if (dl > 0) begin
            dl--;
            if (dl == 0) begin
                dcmp_done = 1;
                fifo_cnt = 64;
            end
        end
        awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        wready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        bvalid = b_pend && (!stall || bvalid || $urandom_range(0, 1) != 0);
        bresp = (bvalid && b_idx == berr_burst) ? 2'd2 : 2'd0;
        ofifo_empty = (fifo_cnt == 0) ||
                      (stall && !w_hold && $urandom_range(0, 3) == 0);
        ofifo_data = (fifo_cnt > 0) ? wpat(fifo_next) : '0;
        #1;
        cyc++;
        if (dcmp_trigger) trig_cyc = cyc;
        if (ar_hold && (!arvalid || araddr !== ar_prev)) stab_bad++;
        ar_hold = arvalid && !arready;
        ar_prev = araddr;
        if (arvalid && arready) begin
            ar_cnt++;
            araddr_s = araddr;
            arlen_s = arlen;
            r_left = int'(arlen) + 1;
            r_idx = 0;
        end
        if (rvalid && rready) begin
            in_cnt++;
            if (!dcmp_in_vld || dcmp_in_data !== rdata) in_bad++;
            if (rlast) rlast_cyc = cyc;
            r_left--;
            r_idx++;
        end else if (dcmp_in_vld) begin
            in_bad++;
        end
        if (dcmp_start) begin
            start_cnt++;
            start_cyc = cyc;
            dl = lat;
        end
        if (aw_hold && (!awvalid || awaddr !== aw_prev)) stab_bad++;
        aw_hold = awvalid && !awready;
        aw_prev = awaddr;
        if (awvalid && awready) begin
            if (aw_cnt < 4) aw_addr[aw_cnt] = awaddr;
            if (awlen != 8'd15) awlen_bad++;
            aw_cnt++;
            aw_open = 1;
        end
        if (w_hold && (!wvalid || wdata !== w_prev)) stab_bad++;
        w_hold = wvalid && !wready;
        w_prev = wdata;
        if (wvalid) begin
            if (!aw_open || awvalid) ovl_bad++;
            if (wdata !== wpat(fifo_next)) w_bad++;
        end
        if (ofifo_rd_en !== (wvalid && wready)) rd_bad++;
        if (wvalid && wready) begin
            if (wlast !== (w_cnt % 16 == 15)) wlast_bad++;
            if (wstrb !== '1) wstrb_bad++;
            w_cnt++;
            fifo_cnt--;
            fifo_next++;
            if (w_cnt % 16 == 0) begin
                aw_open = 0;
                b_pend = 1;
            end
        end
        if (bvalid && bready) begin
            b_pend = 0;
            b_idx++;
        end
        if (tol_upd_vld) begin
            tol_cnt++;
            tol_way_s = tol_upd_way;
        end
        if (dcmp_mngr_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (dcmp_err && (arvalid || awvalid || wvalid || dcmp_in_vld ||
                         dcmp_start || tol_upd_vld || dcmp_mngr_done))
            err_vld_bad++;
        if (trig2_w >= 0 && w_cnt == trig2_w && !trig2_fired) begin
            trig2_fired = 1;
            trig_next = 1;
            dst_way = 'h777;
            cmp_size = 14'd64;
        end
    endtask

    task automatic do_reset(input string tag);
        model_clear();
        rst_ni = 0;
        #1;
        chk({tag, "_vld"}, {arvalid, awvalid, wvalid, rready, bready,
                            dcmp_start, dcmp_in_vld, ofifo_rd_en,
                            tol_upd_vld, dcmp_mngr_done, dcmp_err}, 0);
        chk({tag, "_addr"}, {araddr[31:0], awaddr[31:0]}, 0);
        chk({tag, "_len"}, {arlen, awlen, 12'h0, tol_upd_way[31:0]}, 0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1;
    endtask

    task automatic run(input logic [FW-1:0] way, input logic [11:0] off,
                       input logic [13:0] size, input logic [FW-1:0] dst,
                       input int budget);
        zspg_way = way;
        zspg_off = off;
        cmp_size = size;
        dst_way = dst;
        trig_next = 1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (done_cnt > 0 || dcmp_err) break;
        end
    endtask

    initial begin
        // 64 B chunk, zero-wait slaves
        do_reset("rst0");
        run(36'h12, 12'h080, 14'd64, 36'h345, 500);
        chk("a_done", done_cnt, 1);
        chk("a_ar_cnt", ar_cnt, 1);
        chk("a_araddr", araddr_s, 48'h12080);
        chk("a_arlen", arlen_s, 0);
        chk("a_in", {in_cnt, in_bad}, {32'd1, 32'd0});
        chk("a_start", start_cnt, 1);
        chk("a_start_dly", start_cyc - rlast_cyc, 1);
        chk("a_aw_cnt", aw_cnt, 4);
        chk("a_aw0", aw_addr[0], 48'h345000);
        chk("a_aw1", aw_addr[1], 48'h345400);
        chk("a_aw2", aw_addr[2], 48'h345800);
        chk("a_aw3", aw_addr[3], 48'h345C00);
        chk("a_awlen", awlen_bad, 0);
        chk("a_w_cnt", w_cnt, 64);
        chk("a_w_bad", {w_bad, wlast_bad, wstrb_bad, rd_bad, ovl_bad}, 0);
        chk("a_tol", {tol_cnt, tol_way_s[31:0]}, {32'd1, 32'h345});
        chk("a_latency", done_cyc - trig_cyc + 1, 78);
        repeat (5) step();
        chk("a_pulse", {done_cnt, tol_cnt}, {32'd1, 32'd1});
        chk("a_err", dcmp_err, 0);

        // 128 B chunk with a stale done during the read
        do_reset("rst1");
        early = 1;
        lat = 3;
        run(36'hABCDE, 12'h3C0, 14'd128, 36'h1000, 600);
        chk("b_done", done_cnt, 1);
        chk("b_araddr", araddr_s, 48'hABCDE3C0);
        chk("b_arlen", arlen_s, 1);
        chk("b_in", {in_cnt, in_bad}, {32'd2, 32'd0});
        chk("b_start", {start_cnt, start_cyc - rlast_cyc}, {32'd1, 32'd1});
        chk("b_aw3", aw_addr[3], 48'h1000C00);
        chk("b_w", {w_cnt, w_bad, wlast_bad}, {32'd64, 32'd0, 32'd0});
        chk("b_tol", tol_way_s, 36'h1000);

        // random stalls and FIFO bubbles
        do_reset("rst2");
        stall = 1;
        lat = 5;
        run(36'h7, 12'h040, 14'd128, 36'h2AA, 5000);
        chk("c_done", done_cnt, 1);
        chk("c_w_cnt", w_cnt, 64);
        chk("c_w_bad", {w_bad, wlast_bad, rd_bad, ovl_bad}, 0);
        chk("c_stable", stab_bad, 0);
        chk("c_aw2", aw_addr[2], 48'h2AA800);
        chk("c_in", {in_cnt, in_bad}, {32'd2, 32'd0});

        // rresp error on second chunk beat
        do_reset("rst3");
        rerr_beat = 1;
        run(36'h12, 12'h000, 14'd128, 36'h5, 300);
        repeat (20) step();
        chk("d1_err", dcmp_err, 1);
        chk("d1_quiet", {start_cnt, aw_cnt, tol_cnt, done_cnt}, 0);
        chk("d1_vld", err_vld_bad, 0);
        do_reset("d1_rst");
        #1;
        chk("d1_cleared", dcmp_err, 0);

        // bresp error on burst 2
        do_reset("rst4");
        berr_burst = 2;
        run(36'h12, 12'h000, 14'd64, 36'h5, 500);
        repeat (20) step();
        chk("d2_err", dcmp_err, 1);
        chk("d2_aw_w", {aw_cnt, w_cnt}, {32'd3, 32'd48});
        chk("d2_quiet", {tol_cnt, done_cnt, err_vld_bad}, 0);

        // illegal compressed size
        do_reset("rst5");
        run(36'h12, 12'h000, 14'd96, 36'h5, 50);
        repeat (10) step();
        chk("d3_err", dcmp_err, 1);
        chk("d3_no_ar", ar_cnt, 0);

        // second trigger mid-write is ignored
        do_reset("rst6");
        trig2_w = 5;
        run(36'h21, 12'h100, 14'd64, 36'h99, 500);
        repeat (10) step();
        chk("e_fired", trig2_fired, 1);
        chk("e_counts", {ar_cnt, aw_cnt, done_cnt},
            {32'd1, 32'd4, 32'd1});
        chk("e_tol", tol_way_s, 36'h99);

        // reset mid-burst, then a clean transfer
        do_reset("rst7");
        zspg_way = 36'h33;
        zspg_off = 12'h0C0;
        cmp_size = 14'd64;
        dst_way = 36'h44;
        trig_next = 1;
        for (int i = 0; i < 500; i++) begin
            step();
            if (w_cnt >= 20) break;
        end
        chk("f_reached", w_cnt, 20);
        #2;
        do_reset("f_midrst");
        run(36'h33, 12'h0C0, 14'd64, 36'h44, 500);
        chk("f_done", {done_cnt, w_cnt, w_bad}, {32'd1, 32'd64, 32'd0});
        chk("f_tol", tol_way_s, 36'h44);
        chk("f_aw0", aw_addr[0], 48'h44000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
